dot_operand_collector: RTL

//  Upstream stage of the combinational dot-product unit. Accepts one (a,b) element pair per beat

---
 rtl/dot_pkg.sv | 17 +
 rtl/dot_elem_buffer.sv | 37 +++
 rtl/dot_operand_collector.sv | 109 ++++++++++
 3 files changed

// File: rtl/dot_pkg.sv
// Shared types and sizing helpers for the dot-product operand collector.
// Build option: define DOC_LAST_EN to enable early vector termination via in_last.
package dot_pkg;

    localparam int DOT_N     = 4;
    localparam int DOT_WIDTH = 16;

    typedef enum logic [1:0] {FILL, EVAL, HOLD} doc_state_t;

    typedef logic signed [DOT_WIDTH-1:0] elem_t;

    // Index width for an N-slot buffer; clamped to 1 so N=1 still yields a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dot_elem_buffer.sv
// N x 2 element register file: one indexed write port and a synchronous clear.
module dot_elem_buffer
    import dot_pkg::*;
#(
    parameter int N     = DOT_N,
    parameter int WIDTH = DOT_WIDTH,
    parameter int IW    = idx_w(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [IW-1:0]           wr_idx,
    input  logic [WIDTH-1:0]        wr_a,
    input  logic [WIDTH-1:0]        wr_b,
    output logic [N-1:0][WIDTH-1:0] vec_a,
    output logic [N-1:0][WIDTH-1:0] vec_b
);

    logic [N-1:0][WIDTH-1:0] vec_a_q;
    logic [N-1:0][WIDTH-1:0] vec_b_q;

    // Clear wins over write so a vector never survives into the next fill.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vec_a_q <= '0;
            vec_b_q <= '0;
        end else if (wr_en) begin
            vec_a_q[wr_idx] <= wr_a;
            vec_b_q[wr_idx] <= wr_b;
        end
    end

    assign vec_a = vec_a_q;
    assign vec_b = vec_b_q;

endmodule

// File: rtl/dot_operand_collector.sv
// Collects (a,b) element pairs into N-wide vectors, feeds the dot-product unit and
// offers its registered result downstream. Build option: DOC_LAST_EN adds in_last.
module dot_operand_collector
    import dot_pkg::*;
#(
    parameter int N     = DOT_N,
    parameter int WIDTH = DOT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_a,
    input  logic [WIDTH-1:0]        in_b,
`ifdef DOC_LAST_EN
    input  logic                    in_last,
`endif
    output logic [N-1:0][WIDTH-1:0] dp_a,
    output logic [N-1:0][WIDTH-1:0] dp_b,
    input  logic [WIDTH-1:0]        dp_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_result,
    output doc_state_t              state_dbg
);

    localparam int IW = idx_w(N);

    // Handshake: a transfer happens on a posedge where valid && ready are both high;
    // ready never depends on valid, and valid/data hold until the transfer.
    doc_state_t       state_q;
    logic [IW-1:0]    idx_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;

    logic accept_d;
    logic last_slot_d;
    logic end_vec_d;
    logic clr_d;

    assign in_ready    = (state_q == FILL) && !rst;
    assign accept_d    = in_valid && in_ready;
    assign last_slot_d = (idx_q == IW'(N - 1));
`ifdef DOC_LAST_EN
    assign end_vec_d   = last_slot_d || in_last;
`else
    assign end_vec_d   = last_slot_d;
`endif
    assign clr_d       = (state_q == HOLD) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept_d) begin
                        if (end_vec_d) begin
                            idx_q   <= '0;
                            state_q <= EVAL;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                // Vectors became stable at the end of FILL, so dp_result has settled here.
                EVAL: begin
                    out_result_q <= dp_result;
                    out_valid_q  <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    dot_elem_buffer #(
        .N     (N),
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_d),
        .wr_en  (accept_d),
        .wr_idx (idx_q),
        .wr_a   (in_a),
        .wr_b   (in_b),
        .vec_a  (dp_a),
        .vec_b  (dp_b)
    );

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign state_dbg  = state_q;

endmodule
